// File: rtl/ptpv2_ts_collector_pkg.sv
// Shared types and constants for the ptpv2 timestamp collector: event field
// widths, register offsets, CTRL bit positions and the FIFO entry layout.
package ptpv2_ts_collector_pkg;

    // Per-port event field widths: {sec[47:0], ns[31:0]}, fractional ns, {msgtype, seqid}
    localparam int STD_W  = 80;
    localparam int FNS_W  = 16;
    localparam int MSG_W  = 20;
    localparam int PORT_W = 4;

    // Register offsets inside the 32-byte window
    localparam logic [4:0] OFF_STATUS = 5'h00;
    localparam logic [4:0] OFF_CTRL   = 5'h04;
    localparam logic [4:0] OFF_HEAD0  = 5'h08;
    localparam logic [4:0] OFF_HEAD1  = 5'h0C;
    localparam logic [4:0] OFF_HEAD2  = 5'h10;
    localparam logic [4:0] OFF_HEAD3  = 5'h14;

    // CTRL bit positions
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_FLUSH_BIT  = 1;
    localparam int CTRL_THRESH_LSB = 8;
    localparam int CTRL_THRESH_W   = 8;

    // Word index of a register (byte offset >> 2)
    typedef enum logic [2:0] {
        REG_STATUS = 3'd0,
        REG_CTRL   = 3'd1,
        REG_HEAD0  = 3'd2,
        REG_HEAD1  = 3'd3,
        REG_HEAD2  = 3'd4,
        REG_HEAD3  = 3'd5,
        REG_RSVD6  = 3'd6,
        REG_RSVD7  = 3'd7
    } reg_sel_e;

    // One FIFO entry: source port plus the full captured event
    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [3:0]        msgtype;
        logic [47:0]       sec;
        logic [31:0]       ns;
        logic [15:0]       seqid;
        logic [15:0]       fns;
    } ts_entry_t;

    localparam int ENTRY_W = $bits(ts_entry_t);

    // Saturating add used by the overflow counter (several ports may drop at once)
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [4:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {4'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/ptpv2_sync_fifo.sv
// Single-clock FIFO with push/pop/flush, occupancy level and a combinational
// head output (the entry at the read pointer, no output register).
module ptpv2_sync_fifo #(
    parameter int WIDTH = 120,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Storage array; a push into a full FIFO overwrites the slot being popped that same cycle
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and level bookkeeping; flush wins over push/pop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ptpv2_ts_collector.sv
// Multi-port PTP timestamp collector: per-port hold registers, round-robin
// arbitration into a shared FIFO, and a small bus register block with a
// FIFO-level threshold interrupt.
module ptpv2_ts_collector
    import ptpv2_ts_collector_pkg::*;
#(
    parameter int          NUM_PORTS  = 4,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0200
) (
    input  logic                         bus2ip_clk,
    input  logic                         bus2ip_rst_n,
    input  logic [NUM_PORTS-1:0]         ts_valid_i,
    input  logic [NUM_PORTS*STD_W-1:0]   ts_std_i,
    input  logic [NUM_PORTS*FNS_W-1:0]   ts_fns_i,
    input  logic [NUM_PORTS*MSG_W-1:0]   ts_msg_i,
    input  logic [31:0]                  bus2ip_addr_i,
    input  logic [31:0]                  bus2ip_data_i,
    input  logic                         bus2ip_rd_ce_i,
    input  logic                         bus2ip_wr_ce_i,
    output logic [31:0]                  ip2bus_data_o,
    output logic                         int_ts_o
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // Hold registers, one per port
    logic [NUM_PORTS-1:0] r_hold_vld;
    logic [STD_W-1:0]     r_hold_std [NUM_PORTS];
    logic [FNS_W-1:0]     r_hold_fns [NUM_PORTS];
    logic [MSG_W-1:0]     r_hold_msg [NUM_PORTS];

    // Control / status state
    logic [PORT_W-1:0]        r_last;
    logic                     r_enable;
    logic [CTRL_THRESH_W-1:0] r_thresh;
    logic [7:0]               r_ovf_cnt;
    logic [31:0]              r_rdata;
    logic                     r_int;

    // Bus decode
    logic     w_hit;
    reg_sel_e w_sel;
    logic     w_rd;
    logic     w_ctrl_wr;
    logic     w_flush;
    logic     w_pop;
    logic     w_unused;

    // Arbitration / capture
    logic [NUM_PORTS-1:0] w_grant;
    logic                 w_grant_any;
    logic [PORT_W-1:0]    w_grant_port;
    int                   w_best;
    int                   w_dist;
    logic [NUM_PORTS-1:0] w_load;
    logic [NUM_PORTS-1:0] w_drop;
    logic [4:0]           w_drop_cnt;
    ts_entry_t            w_push_entry;

    // FIFO side
    logic [ENTRY_W-1:0] w_head_vec;
    ts_entry_t          w_head;
    logic [LVL_W-1:0]   w_fifo_level;
    logic [15:0]        w_level16;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [31:0]        w_rd_mux;

    assign w_hit     = (bus2ip_addr_i[31:5] == BASE_ADDR[31:5]);
    assign w_sel     = reg_sel_e'(bus2ip_addr_i[4:2]);
    assign w_rd      = bus2ip_rd_ce_i & w_hit;
    assign w_ctrl_wr = bus2ip_wr_ce_i & w_hit & (w_sel == REG_CTRL);
    assign w_flush   = w_ctrl_wr & bus2ip_data_i[CTRL_FLUSH_BIT];
    assign w_pop     = w_rd & (w_sel == REG_HEAD3) & ~w_fifo_empty & ~w_flush;
    assign w_unused  = ^{bus2ip_data_i[31:16], bus2ip_data_i[7:2], bus2ip_addr_i[1:0]};

    assign w_head    = ts_entry_t'(w_head_vec);
    assign w_level16 = {{(16-LVL_W){1'b0}}, w_fifo_level};

    assign ip2bus_data_o = r_rdata;
    assign int_ts_o      = r_int;

    // Round-robin pick: nearest valid hold after the last granted port, only when the FIFO can take it
    always_comb begin
        w_grant      = '0;
        w_grant_any  = 1'b0;
        w_grant_port = r_last;
        w_best       = NUM_PORTS + 1;
        w_dist       = 0;
        if (!w_flush && (!w_fifo_full || w_pop)) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                w_dist = (j > int'(r_last)) ? (j - int'(r_last)) : (j - int'(r_last) + NUM_PORTS);
                if (r_hold_vld[j] && (w_dist < w_best)) begin
                    w_best       = w_dist;
                    w_grant_any  = 1'b1;
                    w_grant_port = PORT_W'(j);
                end
            end
        end
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_grant[j] = w_grant_any && (w_grant_port == PORT_W'(j));
        end
    end

    // Decide per port whether a new strobe loads its hold register or is dropped as an overflow
    always_comb begin
        w_load     = '0;
        w_drop     = '0;
        w_drop_cnt = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_load[j]  = r_enable & ts_valid_i[j] & (~r_hold_vld[j] | w_grant[j]);
            w_drop[j]  = r_enable & ts_valid_i[j] & r_hold_vld[j] & ~w_grant[j];
            w_drop_cnt = w_drop_cnt + {4'b0, w_drop[j]};
        end
    end

    // Build the FIFO entry from the granted hold register
    always_comb begin
        w_push_entry = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (w_grant[j]) begin
                w_push_entry.port    = PORT_W'(j);
                w_push_entry.msgtype = r_hold_msg[j][19:16];
                w_push_entry.seqid   = r_hold_msg[j][15:0];
                w_push_entry.sec     = r_hold_std[j][79:32];
                w_push_entry.ns      = r_hold_std[j][31:0];
                w_push_entry.fns     = r_hold_fns[j];
            end
        end
    end

    // Hold registers: load on accepted strobe, release on grant, clear on flush
    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            r_hold_vld <= '0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                r_hold_std[j] <= '0;
                r_hold_fns[j] <= '0;
                r_hold_msg[j] <= '0;
            end
        end else if (w_flush) begin
            r_hold_vld <= '0;
        end else begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (w_load[j]) begin
                    r_hold_vld[j] <= 1'b1;
                    r_hold_std[j] <= ts_std_i[j*STD_W +: STD_W];
                    r_hold_fns[j] <= ts_fns_i[j*FNS_W +: FNS_W];
                    r_hold_msg[j] <= ts_msg_i[j*MSG_W +: MSG_W];
                end else if (w_grant[j]) begin
                    r_hold_vld[j] <= 1'b0;
                end
            end
        end
    end

    // Remember the last granted port so the next search starts just after it
    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            r_last <= PORT_W'(NUM_PORTS - 1);
        end else if (w_grant_any) begin
            r_last <= w_grant_port;
        end
    end

    // CTRL register; flush is a pulse derived from the write and is never stored
    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            r_enable <= 1'b0;
            r_thresh <= '0;
        end else if (w_ctrl_wr) begin
            r_enable <= bus2ip_data_i[CTRL_ENABLE_BIT];
            r_thresh <= bus2ip_data_i[CTRL_THRESH_LSB +: CTRL_THRESH_W];
        end
    end

    // Saturating count of events lost because their port's hold was still occupied
    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            r_ovf_cnt <= '0;
        end else if (w_flush) begin
            r_ovf_cnt <= '0;
        end else if (w_drop_cnt != 5'd0) begin
            r_ovf_cnt <= sat_add8(r_ovf_cnt, w_drop_cnt);
        end
    end

    // Shared FIFO of captured events
    ptpv2_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (bus2ip_clk),
        .i_rst_n (bus2ip_rst_n),
        .i_push  (w_grant_any),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head_vec),
        .o_level (w_fifo_level),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Read mux; HEAD words show zero when there is nothing to read
    always_comb begin
        w_rd_mux = '0;
        case (w_sel)
            REG_STATUS: w_rd_mux = {r_ovf_cnt, 6'b0, w_fifo_full, w_fifo_empty, w_level16};
            REG_CTRL:   w_rd_mux = {16'b0, r_thresh, 6'b0, 1'b0, r_enable};
            REG_HEAD0:  if (!w_fifo_empty) w_rd_mux = {w_head.port, w_head.msgtype, 8'b0, w_head.sec[47:32]};
            REG_HEAD1:  if (!w_fifo_empty) w_rd_mux = w_head.sec[31:0];
            REG_HEAD2:  if (!w_fifo_empty) w_rd_mux = w_head.ns;
            REG_HEAD3:  if (!w_fifo_empty) w_rd_mux = {w_head.seqid, w_head.fns};
            default:    w_rd_mux = '0;
        endcase
    end

    // Registered read data, valid for exactly the cycle after a read strobe
    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rd_mux;
        end else begin
            r_rdata <= '0;
        end
    end

    // Level interrupt, one cycle behind the FIFO level
    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            r_int <= 1'b0;
        end else begin
            r_int <= r_enable & (r_thresh != '0) & (w_level16 >= {8'b0, r_thresh});
        end
    end

endmodule
